// File: rtl/go_move_ctrl.sv
// go_move_ctrl: 9x9 Go board owner; cursor, placement, turns, passes, frame-aligned board writes
module go_move_ctrl #(
    parameter bit COMMIT_ON_FRAME = 1'b1,
    parameter bit WRAP_CURSOR     = 1'b0,
    parameter int START_ROW       = 4,
    parameter int START_COL       = 4
) (
    input  logic         vclock_in,
    input  logic         reset_in,
    input  logic         up_in,
    input  logic         down_in,
    input  logic         left_in,
    input  logic         right_in,
    input  logic         place_in,
    input  logic         pass_in,
    input  logic         frame_start_in,
    output logic [161:0] board_out,
    output logic [3:0]   cursor_row_out,
    output logic [3:0]   cursor_col_out,
    output logic         turn_out,
    output logic [7:0]   move_count_out,
    output logic         busy_out,
    output logic         reject_out,
    output logic         game_over_out
);
    typedef enum logic [2:0] {CLEAR, IDLE, PENDING, COMMIT, DONE} state_t;

    state_t         state, state_n;
    logic [6:0]     clr_idx, clr_idx_n, pend_idx, pend_idx_n, cur_idx;
    logic [1:0]     pend_col, pend_col_n, passes, passes_n, cur_cell;
    logic [5:0]     btn, hist, press;
    logic [161:0]   board_n;
    logic [3:0]     row_n, col_n;
    logic           turn_n, reject_n;
    logic [7:0]     mc_n;

    assign btn      = {place_in, pass_in, up_in, down_in, left_in, right_in};
    assign press    = btn & ~hist;
    assign cur_idx  = 7'(cursor_row_out) * 7'd9 + 7'(cursor_col_out);
    assign cur_cell = board_out[{cur_idx, 1'b0} +: 2];

    // Next-state and next-value logic; one action per cycle in IDLE, by priority
    always_comb begin
        state_n    = state;
        clr_idx_n  = clr_idx;
        pend_idx_n = pend_idx;
        pend_col_n = pend_col;
        passes_n   = passes;
        board_n    = board_out;
        row_n      = cursor_row_out;
        col_n      = cursor_col_out;
        turn_n     = turn_out;
        mc_n       = move_count_out;
        reject_n   = 1'b0;
        case (state)
            CLEAR: begin
                board_n[{clr_idx, 1'b0} +: 2] = 2'b00;
                clr_idx_n = clr_idx + 7'd1;
                state_n   = (clr_idx == 7'd80) ? IDLE : CLEAR;
            end
            IDLE: begin
                if (press[5]) begin
                    if (cur_cell != 2'b00) begin
                        reject_n = 1'b1;
                    end else begin
                        pend_idx_n = cur_idx;
                        pend_col_n = turn_out ? 2'b10 : 2'b01;
                        state_n    = PENDING;
                    end
                end else if (press[4]) begin
                    turn_n   = ~turn_out;
                    passes_n = passes + 2'd1;
                    state_n  = (passes == 2'd1) ? DONE : IDLE;
                end else if (press[3]) begin
                    row_n = (cursor_row_out == 4'd0) ? (WRAP_CURSOR ? 4'd8 : 4'd0) : cursor_row_out - 4'd1;
                end else if (press[2]) begin
                    row_n = (cursor_row_out == 4'd8) ? (WRAP_CURSOR ? 4'd0 : 4'd8) : cursor_row_out + 4'd1;
                end else if (press[1]) begin
                    col_n = (cursor_col_out == 4'd0) ? (WRAP_CURSOR ? 4'd8 : 4'd0) : cursor_col_out - 4'd1;
                end else if (press[0]) begin
                    col_n = (cursor_col_out == 4'd8) ? (WRAP_CURSOR ? 4'd0 : 4'd8) : cursor_col_out + 4'd1;
                end
            end
            PENDING: state_n = (!COMMIT_ON_FRAME || frame_start_in) ? COMMIT : PENDING;
            COMMIT: begin
                board_n[{pend_idx, 1'b0} +: 2] = pend_col;
                turn_n   = ~turn_out;
                mc_n     = (move_count_out == 8'hFF) ? move_count_out : move_count_out + 8'd1;
                passes_n = 2'd0;
                state_n  = IDLE;
            end
            default: ;
        endcase
    end

    // State register and registered outputs; button history tracks levels in every state
    always_ff @(posedge vclock_in) begin
        if (!reset_in) begin
            state          <= CLEAR;
            clr_idx        <= 7'd0;
            pend_idx       <= 7'd0;
            pend_col       <= 2'b00;
            passes         <= 2'd0;
            hist           <= 6'h3F;
            board_out      <= '0;
            cursor_row_out <= 4'(START_ROW);
            cursor_col_out <= 4'(START_COL);
            turn_out       <= 1'b0;
            move_count_out <= 8'd0;
            busy_out       <= 1'b1;
            reject_out     <= 1'b0;
            game_over_out  <= 1'b0;
        end else begin
            state          <= state_n;
            clr_idx        <= clr_idx_n;
            pend_idx       <= pend_idx_n;
            pend_col       <= pend_col_n;
            passes         <= passes_n;
            hist           <= btn;
            board_out      <= board_n;
            cursor_row_out <= row_n;
            cursor_col_out <= col_n;
            turn_out       <= turn_n;
            move_count_out <= mc_n;
            busy_out       <= (state_n == CLEAR) || (state_n == PENDING) || (state_n == COMMIT);
            reject_out     <= reject_n;
            game_over_out  <= (state_n == DONE);
        end
    end
endmodule

// File: tb/tb_go_move_ctrl.sv
// tb_go_move_ctrl: directed scenario tests for go_move_ctrl (frame commit/saturating cursor, and immediate commit/wrapping cursor)
`timescale 1ns/1ps
module tb_go_move_ctrl;
    logic         vclock_in = 1'b0;
    logic         reset_in = 1'b0;
    logic         up_in = 1'b0, down_in = 1'b0, left_in = 1'b0, right_in = 1'b0;
    logic         place_in = 1'b0, pass_in = 1'b0, frame_start_in = 1'b0;
    logic [161:0] board_out;
    logic [3:0]   cursor_row_out, cursor_col_out;
    logic         turn_out, busy_out, reject_out, game_over_out;
    logic [7:0]   move_count_out;

    logic         w_up = 1'b0, w_down = 1'b0, w_place = 1'b0;
    logic [161:0] w_board;
    logic [3:0]   w_row, w_col;
    logic         w_turn, w_busy, w_reject, w_over;
    logic [7:0]   w_mc;

    int checks = 0;
    int fails = 0;

    always #8 vclock_in = ~vclock_in;

    go_move_ctrl dut (
        .vclock_in(vclock_in), .reset_in(reset_in),
        .up_in(up_in), .down_in(down_in), .left_in(left_in), .right_in(right_in),
        .place_in(place_in), .pass_in(pass_in), .frame_start_in(frame_start_in),
        .board_out(board_out), .cursor_row_out(cursor_row_out), .cursor_col_out(cursor_col_out),
        .turn_out(turn_out), .move_count_out(move_count_out), .busy_out(busy_out),
        .reject_out(reject_out), .game_over_out(game_over_out)
    );

    go_move_ctrl #(.COMMIT_ON_FRAME(1'b0), .WRAP_CURSOR(1'b1)) dut_w (
        .vclock_in(vclock_in), .reset_in(reset_in),
        .up_in(w_up), .down_in(w_down), .left_in(1'b0), .right_in(1'b0),
        .place_in(w_place), .pass_in(1'b0), .frame_start_in(1'b0),
        .board_out(w_board), .cursor_row_out(w_row), .cursor_col_out(w_col),
        .turn_out(w_turn), .move_count_out(w_mc), .busy_out(w_busy),
        .reject_out(w_reject), .game_over_out(w_over)
    );

    task automatic tick();
        @(posedge vclock_in);
        #1;
    endtask

    // mask order: place, pass, up, down, left, right
    task automatic press(input logic [5:0] m);
        {place_in, pass_in, up_in, down_in, left_in, right_in} = m;
        tick();
        {place_in, pass_in, up_in, down_in, left_in, right_in} = 6'b0;
        tick();
    endtask

    task automatic do_reset();
        reset_in = 1'b0;
        tick();
        tick();
        reset_in = 1'b1;
        repeat (81) tick();
    endtask

    task automatic test_reset();
        int n;
        reset_in = 1'b0;
        tick();
        tick();
        checks++; if (busy_out !== 1'b1) begin fails++; $display("FAIL reset_busy: got %b expected 1", busy_out); end
        checks++; if (board_out !== '0) begin fails++; $display("FAIL reset_board: got %h expected 0", board_out); end
        checks++; if ({cursor_row_out, cursor_col_out} !== 8'h44) begin fails++; $display("FAIL reset_cursor: got %h expected 44", {cursor_row_out, cursor_col_out}); end
        checks++; if ({turn_out, reject_out, game_over_out} !== 3'b000) begin fails++; $display("FAIL reset_flags: got %b expected 000", {turn_out, reject_out, game_over_out}); end
        checks++; if (move_count_out !== 8'd0) begin fails++; $display("FAIL reset_count: got %0d expected 0", move_count_out); end
        reset_in = 1'b1;
        n = 0;
        while (n < 200) begin
            tick();
            n++;
            if (busy_out === 1'b0) break;
        end
        checks++; if (n !== 81) begin fails++; $display("FAIL clear_cycles: got %0d expected 81", n); end
        checks++; if (board_out !== '0) begin fails++; $display("FAIL clear_board: got %h expected 0", board_out); end
    endtask

    task automatic test_held_through_reset();
        int rej;
        reset_in = 1'b0;
        place_in = 1'b1;
        tick();
        tick();
        reset_in = 1'b1;
        rej = 0;
        repeat (90) begin
            tick();
            if (reject_out !== 1'b0) rej++;
        end
        checks++; if (rej !== 0) begin fails++; $display("FAIL held_reject: got %0d pulses expected 0", rej); end
        checks++; if (busy_out !== 1'b0) begin fails++; $display("FAIL held_busy: got %b expected 0", busy_out); end
        checks++; if (move_count_out !== 8'd0) begin fails++; $display("FAIL held_count: got %0d expected 0", move_count_out); end
        place_in = 1'b0;
        tick();
    endtask

    task automatic test_place_frame();
        int bad;
        place_in = 1'b1;
        frame_start_in = 1'b1;
        tick();
        place_in = 1'b0;
        frame_start_in = 1'b0;
        bad = 0;
        repeat (100) begin
            tick();
            if (busy_out !== 1'b1 || board_out !== '0) bad++;
        end
        checks++; if (bad !== 0) begin fails++; $display("FAIL pending_wait: got %0d bad cycles expected 0", bad); end
        frame_start_in = 1'b1;
        tick();
        frame_start_in = 1'b0;
        checks++; if (board_out[81:80] !== 2'b00) begin fails++; $display("FAIL commit_early: got %b expected 00", board_out[81:80]); end
        tick();
        checks++; if (board_out[81:80] !== 2'b01) begin fails++; $display("FAIL commit_cell: got %b expected 01", board_out[81:80]); end
        checks++; if ((board_out & ~(162'b11 << 80)) !== '0) begin fails++; $display("FAIL commit_others: got %h expected 0", board_out); end
        checks++; if ({turn_out, busy_out} !== 2'b10) begin fails++; $display("FAIL commit_turn_busy: got %b expected 10", {turn_out, busy_out}); end
        checks++; if (move_count_out !== 8'd1) begin fails++; $display("FAIL commit_count: got %0d expected 1", move_count_out); end
    endtask

    task automatic test_reject();
        place_in = 1'b1;
        tick();
        place_in = 1'b0;
        checks++; if ({reject_out, busy_out} !== 2'b10) begin fails++; $display("FAIL reject_pulse: got %b expected 10", {reject_out, busy_out}); end
        tick();
        checks++; if (reject_out !== 1'b0) begin fails++; $display("FAIL reject_width: got %b expected 0", reject_out); end
        checks++; if (board_out !== (162'b01 << 80)) begin fails++; $display("FAIL reject_board: got %h expected %h", board_out, 162'b01 << 80); end
        checks++; if ({turn_out, move_count_out} !== {1'b1, 8'd1}) begin fails++; $display("FAIL reject_state: got %h expected 101", {turn_out, move_count_out}); end
    endtask

    task automatic test_cursor();
        repeat (5) press(6'b001000);
        checks++; if ({cursor_row_out, cursor_col_out} !== 8'h04) begin fails++; $display("FAIL up_saturate: got %h expected 04", {cursor_row_out, cursor_col_out}); end
        place_in = 1'b1;
        right_in = 1'b1;
        tick();
        place_in = 1'b0;
        right_in = 1'b0;
        checks++; if ({cursor_col_out, busy_out} !== {4'd4, 1'b1}) begin fails++; $display("FAIL place_over_right: got %h expected 9", {cursor_col_out, busy_out}); end
        tick();
        frame_start_in = 1'b1;
        tick();
        frame_start_in = 1'b0;
        tick();
        checks++; if (board_out[9:8] !== 2'b10) begin fails++; $display("FAIL white_cell: got %b expected 10", board_out[9:8]); end
        checks++; if ({turn_out, move_count_out} !== {1'b0, 8'd2}) begin fails++; $display("FAIL white_state: got %h expected 002", {turn_out, move_count_out}); end
    endtask

    task automatic test_pass();
        logic [161:0] b;
        b = board_out;
        press(6'b010000);
        checks++; if ({turn_out, game_over_out} !== 2'b10) begin fails++; $display("FAIL pass1: got %b expected 10", {turn_out, game_over_out}); end
        press(6'b010000);
        checks++; if ({turn_out, game_over_out} !== 2'b01) begin fails++; $display("FAIL pass2_done: got %b expected 01", {turn_out, game_over_out}); end
        press(6'b100000);
        press(6'b000100);
        checks++; if ({reject_out, busy_out, game_over_out} !== 3'b001) begin fails++; $display("FAIL done_place: got %b expected 001", {reject_out, busy_out, game_over_out}); end
        checks++; if ({cursor_row_out, move_count_out} !== {4'd0, 8'd2} || board_out !== b) begin fails++; $display("FAIL done_frozen: got %h expected 002", {cursor_row_out, move_count_out}); end
    endtask

    task automatic test_pass_commit();
        do_reset();
        press(6'b010000);
        place_in = 1'b1;
        tick();
        place_in = 1'b0;
        tick();
        frame_start_in = 1'b1;
        tick();
        frame_start_in = 1'b0;
        tick();
        checks++; if ({turn_out, move_count_out} !== {1'b0, 8'd1}) begin fails++; $display("FAIL pc_commit: got %h expected 001", {turn_out, move_count_out}); end
        press(6'b010000);
        checks++; if ({turn_out, game_over_out} !== 2'b10) begin fails++; $display("FAIL pc_no_done: got %b expected 10", {turn_out, game_over_out}); end
        checks++; if (board_out[81:80] !== 2'b10) begin fails++; $display("FAIL pc_cell: got %b expected 10", board_out[81:80]); end
    endtask

    task automatic test_reset_pending();
        do_reset();
        press(6'b000010);
        place_in = 1'b1;
        tick();
        place_in = 1'b0;
        checks++; if (busy_out !== 1'b1) begin fails++; $display("FAIL rp_pending: got %b expected 1", busy_out); end
        reset_in = 1'b0;
        frame_start_in = 1'b1;
        tick();
        frame_start_in = 1'b0;
        tick();
        reset_in = 1'b1;
        repeat (81) tick();
        frame_start_in = 1'b1;
        tick();
        frame_start_in = 1'b0;
        tick();
        tick();
        checks++; if (board_out !== '0) begin fails++; $display("FAIL rp_board: got %h expected 0", board_out); end
        checks++; if ({busy_out, move_count_out} !== 9'd0) begin fails++; $display("FAIL rp_state: got %h expected 0", {busy_out, move_count_out}); end
    endtask

    task automatic test_wrap_fast();
        repeat (4) begin
            w_up = 1'b1; tick(); w_up = 1'b0; tick();
        end
        checks++; if (w_row !== 4'd0) begin fails++; $display("FAIL w_up4: got %0d expected 0", w_row); end
        w_up = 1'b1; tick(); w_up = 1'b0; tick();
        checks++; if (w_row !== 4'd8) begin fails++; $display("FAIL w_wrap_up: got %0d expected 8", w_row); end
        w_down = 1'b1; tick(); w_down = 1'b0; tick();
        checks++; if (w_row !== 4'd0) begin fails++; $display("FAIL w_wrap_down: got %0d expected 0", w_row); end
        w_place = 1'b1;
        tick();
        w_place = 1'b0;
        checks++; if ({w_busy, w_board[9:8]} !== 3'b100) begin fails++; $display("FAIL w_cycle1: got %b expected 100", {w_busy, w_board[9:8]}); end
        tick();
        checks++; if ({w_busy, w_board[9:8]} !== 3'b100) begin fails++; $display("FAIL w_cycle2: got %b expected 100", {w_busy, w_board[9:8]}); end
        tick();
        checks++; if ({w_busy, w_board[9:8]} !== 3'b001) begin fails++; $display("FAIL w_cycle3: got %b expected 001", {w_busy, w_board[9:8]}); end
        checks++; if ({w_turn, w_mc} !== {1'b1, 8'd1}) begin fails++; $display("FAIL w_state: got %h expected 101", {w_turn, w_mc}); end
    endtask

    // Scenario sequence; each task leaves both instances in a known state for the next
    initial begin
        test_reset();
        test_held_through_reset();
        test_place_frame();
        test_reject();
        test_cursor();
        test_pass();
        test_pass_commit();
        test_reset_pending();
        test_wrap_fast();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/go_move_ctrl.md
Name: go_move_ctrl

Overview:
- Owns the 9x9 Go board state and sequences every change to it.
- Reads debounced button levels, moves a cursor, validates and places stones, alternates turns, and handles passes and end of game.
- Defers every board write to the vertical-blank boundary so the renderer never sees a board change mid-frame.
- Sits between the debounce modules and go_game; drives go_game's board input and the cursor overlay.

Parameters:
- COMMIT_ON_FRAME, 1: 1 = a placed stone is written on the next frame_start_in pulse; 0 = it is written the cycle after PENDING is entered.
- WRAP_CURSOR, 0: 0 = cursor saturates at 0 and 8; 1 = cursor wraps 8->0 and 0->8.
- START_ROW, 4: cursor row after reset.
- START_COL, 4: cursor column after reset.

Ports:
- vclock_in  in  1  65 MHz pixel clock.
- reset_in  in  1  synchronous, active-low reset.
- up_in, down_in, left_in, right_in  in  1 each  debounced levels; the rising edge is the action.
- place_in  in  1  debounced level; rising edge = place stone at cursor.
- pass_in  in  1  debounced level; rising edge = pass.
- frame_start_in  in  1  one-cycle pulse at start of vertical blank.
- board_out  out  162  cell (r,c) occupies bits [2*(9r+c)+1 : 2*(9r+c)]; 00 empty, 01 black, 10 white, 11 never driven.
- cursor_row_out  out  4  0..8.
- cursor_col_out  out  4  0..8.
- turn_out  out  1  0 = black to move, 1 = white to move.
- move_count_out  out  8  stones placed; saturates at 255.
- busy_out  out  1  high in CLEAR, PENDING and COMMIT.
- reject_out  out  1  one-cycle pulse on an illegal place.
- game_over_out  out  1  high in DONE.

Behaviour:
- Reset (reset_in==0 at a clock edge):
  - state=CLEAR, clear index=0, board_out=0.
  - cursor = (START_ROW, START_COL); turn_out=0; move_count_out=0; pass count=0.
  - reject_out=0, game_over_out=0, busy_out=1.
  - Edge-detect history regs are set to 1, so a button held through reset does not fire.
  - Reset asserted in any state, including mid-CLEAR or PENDING, aborts that operation. A latched pending move is discarded.
- Edge detect:
  - press = level & ~history; history <= level every cycle in all states.
  - A press that arrives in a state that ignores it is dropped, not queued.
- CLEAR:
  - Writes 00 to the cell at the clear index, one cell per cycle.
  - Index runs 0..80; after writing 80, next state = IDLE.
  - Takes 81 cycles from reset release. busy_out=1 throughout.
- IDLE:
  - At most one action per cycle. Priority: place > pass > up > down > left > right. Lower-priority presses in the same cycle are dropped.
  - up: row-1. down: row+1. left: col-1. right: col+1.
  - At a bound the cursor holds when WRAP_CURSOR=0 and wraps when WRAP_CURSOR=1.
  - place, cell non-empty: reject_out=1 for exactly one cycle; state stays IDLE; nothing else changes.
  - place, cell empty: latch index=9*row+col and colour = turn_out ? 10 : 01; next state = PENDING. The cursor may move later without affecting the latched cell.
  - pass: turn_out toggles the next cycle; pass count increments. If the new pass count = 2, next state = DONE.
- PENDING:
  - COMMIT_ON_FRAME=1: waits for frame_start_in. A frame_start_in coincident with the place press (still in IDLE) does not count.
  - COMMIT_ON_FRAME=0: moves to COMMIT after one cycle.
  - All button presses are ignored.
- COMMIT (exactly one cycle):
  - Writes the latched colour into the latched cell; board_out shows it on the following cycle.
  - Toggles turn_out.
  - move_count_out += 1, saturating at 255.
  - Pass count = 0.
  - Next state = IDLE.
- DONE:
  - game_over_out=1. All inputs except reset are ignored.
  - board_out, cursor, turn_out and move_count_out are frozen.
- All outputs are registered. A legal place takes exactly 2 cycles from press to board_out update when COMMIT_ON_FRAME=0.
- Pass count is 2 bits and never exceeds 2.

Test Plan:
- Reset release, no buttons -> busy_out=1 for 81 cycles, then 0; board_out=0; cursor=(4,4); turn_out=0.
- Reset held low with place_in=1, then released and place_in kept high -> no placement and no reject; move_count_out stays 0.
- place at (4,4), COMMIT_ON_FRAME=1, frame_start_in after 100 cycles -> bits[81:80]=01 only after the pulse; turn_out=1; move_count_out=1; busy_out high in between.
- Second place at (4,4) -> reject_out high for exactly 1 cycle; board_out, turn_out and move_count_out unchanged.
- Cursor moves:
  - 5 up presses from row 4 with WRAP_CURSOR=0 -> row=0.
  - 1 up press from row 0 with WRAP_CURSOR=1 -> row=8.
  - place and right pressed in the same cycle -> place only; column unchanged.
- Passes:
  - pass, pass -> game_over_out=1 and turn_out back to 0.
  - A later place press -> ignored.
  - pass, place (committed), pass -> no DONE; pass count restarted by the commit.
  - Reset asserted during PENDING -> pending move never written; board_out=0.
